axil_reg_bank: RTL and testbench

AXIL_REG_BANK -- requirements
Module: axil_reg_bank

---
 rtl/axil_reg_bank.sv | 190 +++++++++++++++++++
 tb/tb_axil_reg_bank.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers, with per-register write pulses.
// Independent write (AW/W/B) and read (AR/R) state machines.
module axil_reg_bank #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS       = 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_lite_s_awaddr,
  input  logic                      axi_lite_s_awvalid,
  output logic                      axi_lite_s_awready,
  input  logic [31:0]               axi_lite_s_wdata,
  input  logic [3:0]                axi_lite_s_wstrb,
  input  logic                      axi_lite_s_wvalid,
  output logic                      axi_lite_s_wready,
  output logic [1:0]                axi_lite_s_bresp,
  output logic                      axi_lite_s_bvalid,
  input  logic                      axi_lite_s_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_lite_s_araddr,
  input  logic                      axi_lite_s_arvalid,
  output logic                      axi_lite_s_arready,
  output logic [31:0]               axi_lite_s_rdata,
  output logic [1:0]                axi_lite_s_rresp,
  output logic                      axi_lite_s_rvalid,
  input  logic                      axi_lite_s_rready,
  output logic [32*NUM_REGS-1:0]    reg_out,
  output logic [NUM_REGS-1:0]       reg_wr_pulse
);

  localparam int unsigned IDX_W       = AXI_ADDR_WIDTH - 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  w_state_e             w_state_q, w_state_d;
  r_state_e             r_state_q, r_state_d;
  logic [IDX_W-1:0]     awidx_q, awidx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic                 awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                 arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]           bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [31:0]          regs_q [NUM_REGS];
  logic [31:0]          regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]  pulse_q, pulse_d;

  logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic                 wr_in_range, rd_in_range;
  logic [IDX_W-1:0]     wr_idx, rd_idx;
  logic [31:0]          wr_data;
  logic [3:0]           wr_strb;
  logic                 unused_addr_lsbs;

  assign unused_addr_lsbs = ^{axi_lite_s_awaddr[1:0], axi_lite_s_araddr[1:0]};

  assign aw_hs = axi_lite_s_awvalid & awready_q;
  assign w_hs  = axi_lite_s_wvalid  & wready_q;
  assign b_hs  = bvalid_q & axi_lite_s_bready;
  assign ar_hs = axi_lite_s_arvalid & arready_q;
  assign r_hs  = rvalid_q & axi_lite_s_rready;

  // A channel handshaking this cycle supplies its value directly; otherwise use the latched copy.
  assign wr_idx      = aw_hs ? axi_lite_s_awaddr[AXI_ADDR_WIDTH-1:2] : awidx_q;
  assign wr_data     = w_hs ? axi_lite_s_wdata : wdata_q;
  assign wr_strb     = w_hs ? axi_lite_s_wstrb : wstrb_q;
  assign wr_in_range = 64'(wr_idx) < 64'(NUM_REGS);
  assign rd_idx      = axi_lite_s_araddr[AXI_ADDR_WIDTH-1:2];
  assign rd_in_range = 64'(rd_idx) < 64'(NUM_REGS);

  // Write path: next state, register commit and write response
  always_comb begin
    w_state_d = w_state_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    pulse_d   = '0;
    commit    = 1'b0;
    if (aw_hs) awidx_d = axi_lite_s_awaddr[AXI_ADDR_WIDTH-1:2];
    if (w_hs) begin
      wdata_d = axi_lite_s_wdata;
      wstrb_d = axi_lite_s_wstrb;
    end
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_d = W_RESP;
        else if (aw_hs)    w_state_d = W_HAVE_AW;
        else if (w_hs)     w_state_d = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  w_state_d = W_RESP;
      W_HAVE_W:  if (aw_hs) w_state_d = W_RESP;
      W_RESP:    if (b_hs)  w_state_d = W_IDLE;
      default:   w_state_d = W_IDLE;
    endcase
    commit = (w_state_d == W_RESP) && (w_state_q != W_RESP);
    if (commit) begin
      bresp_d = wr_in_range ? RESP_OKAY : RESP_SLVERR;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (64'(wr_idx) == 64'(i)) begin
          pulse_d[i] = 1'b1;
          for (int unsigned k = 0; k < 4; k++) begin
            if (wr_strb[k]) regs_d[i][8*k +: 8] = wr_data[8*k +: 8];
          end
        end
      end
    end
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_AW);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Read path: data is captured from the pre-write register state
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          rdata_d   = '0;
          rresp_d   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (64'(rd_idx) == 64'(i)) rdata_d = regs_q[i];
          end
        end
      end
      R_DATA:  if (r_hs) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      regs_q    <= '{default: '0};
      pulse_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
      pulse_q   <= pulse_d;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) reg_out[32*i +: 32] = regs_q[i];
  end

  assign axi_lite_s_awready = awready_q;
  assign axi_lite_s_wready  = wready_q;
  assign axi_lite_s_bvalid  = bvalid_q;
  assign axi_lite_s_bresp   = bresp_q;
  assign axi_lite_s_arready = arready_q;
  assign axi_lite_s_rvalid  = rvalid_q;
  assign axi_lite_s_rresp   = rresp_q;
  assign axi_lite_s_rdata   = rdata_q;
  assign reg_wr_pulse       = pulse_q;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Bench for axil_reg_bank: directed scenarios plus randomized traffic against
// an array-based model of the register file.
module tb_axil_reg_bank;
  localparam int unsigned AW = 32;
  localparam int unsigned NR = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [32*NR-1:0] reg_out;
  logic [NR-1:0]    reg_wr_pulse;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  axil_reg_bank #(.AXI_ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .aclk(clk), .areset(areset),
    .axi_lite_s_awaddr(awaddr), .axi_lite_s_awvalid(awvalid), .axi_lite_s_awready(awready),
    .axi_lite_s_wdata(wdata), .axi_lite_s_wstrb(wstrb), .axi_lite_s_wvalid(wvalid),
    .axi_lite_s_wready(wready), .axi_lite_s_bresp(bresp), .axi_lite_s_bvalid(bvalid),
    .axi_lite_s_bready(bready), .axi_lite_s_araddr(araddr), .axi_lite_s_arvalid(arvalid),
    .axi_lite_s_arready(arready), .axi_lite_s_rdata(rdata), .axi_lite_s_rresp(rresp),
    .axi_lite_s_rvalid(rvalid), .axi_lite_s_rready(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  // Reference register file
  logic [31:0] model [NR];

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb, output logic [1:0] resp,
                                      output logic [NR-1:0] pulse);
    int unsigned idx = addr >> 2;
    pulse = '0;
    resp  = 2'b10;
    if (idx < NR) begin
      resp = 2'b00;
      pulse[idx] = 1'b1;
      for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
    end
  endfunction

  function automatic void model_read(input logic [31:0] addr, output logic [31:0] data,
                                     output logic [1:0] resp);
    int unsigned idx = addr >> 2;
    data = (idx < NR) ? model[idx] : 32'h0;
    resp = (idx < NR) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [32*NR-1:0] model_vec();
    logic [32*NR-1:0] v;
    for (int i = 0; i < NR; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  // gap > 0: AW leads W by gap cycles; gap < 0: W leads AW; 0: together
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int gap, output logic bv, output logic [1:0] resp,
                          output logic [NR-1:0] pulse, output logic [32*NR-1:0] regs,
                          output bit early, output bit tmo);
    int aw_start, w_start, c;
    bit aw_done, w_done, aw_hs, w_hs;
    aw_start = (gap < 0) ? -gap : 0;
    w_start  = (gap > 0) ? gap : 0;
    aw_done = 0; w_done = 0; early = 0; tmo = 0; c = 0;
    while (!(aw_done && w_done)) begin
      awvalid = !aw_done && (c >= aw_start);
      awaddr  = awvalid ? addr : $urandom;
      wvalid  = !w_done && (c >= w_start);
      wdata   = wvalid ? data : $urandom;
      wstrb   = wvalid ? strb : 4'($urandom);
      if (bvalid) early = 1;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      aw_done |= aw_hs;
      w_done  |= w_hs;
      c++;
      if (c > 40) begin tmo = 1; break; end
    end
    awvalid = 0; wvalid = 0;
    bv = bvalid; resp = bresp; pulse = reg_wr_pulse; regs = reg_out;
    if (bready) begin @(posedge clk); #1; end
  endtask

  task automatic do_read(input logic [31:0] addr, output logic rv, output logic [31:0] data,
                         output logic [1:0] resp, output bit tmo);
    bit hs;
    int c;
    c = 0; tmo = 0;
    araddr = addr; arvalid = 1;
    do begin
      hs = arready;
      @(posedge clk); #1;
      c++;
    end while (!hs && c < 40);
    tmo = !hs;
    arvalid = 0; araddr = $urandom;
    rv = rvalid; data = rdata; resp = rresp;
    if (rready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    areset = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (reg_out !== '0) begin n_err++; $display("FAIL reset_regs: got %h expected 0", reg_out); end
    n_vec++; if ({awready, wready, arready} !== 3'b000) begin n_err++; $display("FAIL reset_readies: got %b expected 000", {awready, wready, arready}); end
    n_vec++; if ({bvalid, rvalid, reg_wr_pulse} !== '0) begin n_err++; $display("FAIL reset_valids: got %b expected 0", {bvalid, rvalid, reg_wr_pulse}); end
    areset = 0;
    @(posedge clk); #1;
    n_vec++; if ({awready, wready, arready} !== 3'b111) begin n_err++; $display("FAIL post_reset_readies: got %b expected 111", {awready, wready, arready}); end
    n_vec++; if ({bresp, rresp, rdata} !== '0) begin n_err++; $display("FAIL post_reset_resp: got %h expected 0", {bresp, rresp, rdata}); end
  endtask

  task automatic test_simultaneous_write();
    logic bv; logic [1:0] resp, eresp; logic [NR-1:0] pulse, epulse; logic [32*NR-1:0] regs; bit early, tmo;
    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, bv, resp, pulse, regs, early, tmo);
    model_write(32'h4, 32'hDEADBEEF, 4'hF, eresp, epulse);
    n_vec++; if (tmo || bv !== 1'b1) begin n_err++; $display("FAIL simul_bvalid: got %b expected 1", bv); end
    n_vec++; if (resp !== 2'b00) begin n_err++; $display("FAIL simul_bresp: got %b expected 00", resp); end
    n_vec++; if (regs[32*1 +: 32] !== 32'hDEADBEEF) begin n_err++; $display("FAIL simul_reg1: got %h expected deadbeef", regs[32*1 +: 32]); end
    n_vec++; if (pulse !== 8'h02) begin n_err++; $display("FAIL simul_pulse: got %h expected 02", pulse); end
    n_vec++; if ({bvalid, reg_wr_pulse} !== '0) begin n_err++; $display("FAIL simul_after_b: got %b expected 0", {bvalid, reg_wr_pulse}); end
  endtask

  task automatic test_backpressure();
    logic bv, rv; logic [1:0] resp, eresp, rr; logic [NR-1:0] pulse, epulse; logic [32*NR-1:0] regs;
    logic [31:0] rd, d; bit early, tmo, rtmo, held_ok;
    d = $urandom;
    bready = 0;
    do_write(32'h10, d, 4'hF, 0, bv, resp, pulse, regs, early, tmo);
    model_write(32'h10, d, 4'hF, eresp, epulse);
    held_ok = !tmo && bv;
    fork
      do_read(32'h4, rv, rd, rr, rtmo);
      for (int i = 0; i < 5; i++) begin
        if (!(bvalid === 1'b1 && awready === 1'b0 && wready === 1'b0 && bresp === 2'b00)) held_ok = 0;
        @(posedge clk); #1;
      end
    join
    n_vec++; if (!held_ok) begin n_err++; $display("FAIL bp_hold: got bvalid=%b awready=%b wready=%b expected 1,0,0", bvalid, awready, wready); end
    n_vec++; if (rtmo || rv !== 1'b1 || rd !== 32'hDEADBEEF || rr !== 2'b00) begin n_err++; $display("FAIL bp_read: got %h/%b expected deadbeef/00", rd, rr); end
    n_vec++; if (regs[32*4 +: 32] !== d) begin n_err++; $display("FAIL bp_reg4: got %h expected %h", regs[32*4 +: 32], d); end
    bready = 1;
    @(posedge clk); #1;
    n_vec++; if (bvalid !== 1'b0 || awready !== 1'b1) begin n_err++; $display("FAIL bp_release: got bvalid=%b awready=%b expected 0,1", bvalid, awready); end
  endtask

  task automatic test_split_write();
    logic bv; logic [1:0] resp, eresp; logic [NR-1:0] pulse, epulse; logic [32*NR-1:0] regs; bit early, tmo;
    do_write(32'h8, 32'hFFFFFFFF, 4'hF, 0, bv, resp, pulse, regs, early, tmo);
    model_write(32'h8, 32'hFFFFFFFF, 4'hF, eresp, epulse);
    do_write(32'h8, 32'h11223344, 4'b0101, 3, bv, resp, pulse, regs, early, tmo);
    model_write(32'h8, 32'h11223344, 4'b0101, eresp, epulse);
    n_vec++; if (regs[32*2 +: 32] !== 32'hFF22FF44) begin n_err++; $display("FAIL split_reg2: got %h expected ff22ff44", regs[32*2 +: 32]); end
    n_vec++; if (tmo || early || bv !== 1'b1) begin n_err++; $display("FAIL split_bvalid_timing: got early=%b bv=%b expected 0,1", early, bv); end
    n_vec++; if (pulse !== 8'h04) begin n_err++; $display("FAIL split_pulse: got %h expected 04", pulse); end
  endtask

  task automatic test_out_of_range();
    logic bv, rv; logic [1:0] resp, rr; logic [NR-1:0] pulse; logic [32*NR-1:0] regs;
    logic [31:0] rd; bit early, tmo;
    do_write(32'h20, 32'hA5A5A5A5, 4'hF, 0, bv, resp, pulse, regs, early, tmo);
    n_vec++; if (tmo || bv !== 1'b1 || resp !== 2'b10) begin n_err++; $display("FAIL oor_bresp: got %b expected 10", resp); end
    n_vec++; if (pulse !== '0) begin n_err++; $display("FAIL oor_pulse: got %h expected 00", pulse); end
    n_vec++; if (regs !== model_vec()) begin n_err++; $display("FAIL oor_regs: got %h expected %h", regs, model_vec()); end
    do_read(32'h20, rv, rd, rr, tmo);
    n_vec++; if (tmo || rv !== 1'b1 || rd !== 32'h0 || rr !== 2'b10) begin n_err++; $display("FAIL oor_read: got %h/%b expected 0/10", rd, rr); end
  endtask

  task automatic test_collision();
    logic bv, rv; logic [1:0] resp, eresp, rr; logic [NR-1:0] pulse, epulse; logic [32*NR-1:0] regs;
    logic [31:0] rd; bit early, tmo, rtmo;
    fork
      do_write(32'hC, 32'h5, 4'hF, 0, bv, resp, pulse, regs, early, tmo);
      do_read(32'hC, rv, rd, rr, rtmo);
    join
    n_vec++; if (rtmo || rv !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL collide_old: got %h expected 0", rd); end
    model_write(32'hC, 32'h5, 4'hF, eresp, epulse);
    do_read(32'hC, rv, rd, rr, rtmo);
    n_vec++; if (rtmo || rd !== 32'h5) begin n_err++; $display("FAIL collide_new: got %h expected 5", rd); end
  endtask

  task automatic test_back_to_back();
    logic bv, rv; logic [1:0] resp, eresp, rr, err; logic [NR-1:0] pulse, epulse; logic [32*NR-1:0] regs;
    logic [31:0] rd, ed, a, d; bit early, tmo, ok;
    int unsigned t0;
    ok = 1; t0 = cyc_cnt;
    for (int i = 0; i < 4; i++) begin
      a = 32'($urandom_range(0, NR-1)) << 2; d = $urandom;
      do_write(a, d, 4'hF, 0, bv, resp, pulse, regs, early, tmo);
      model_write(a, d, 4'hF, eresp, epulse);
      if (tmo || regs !== model_vec()) ok = 0;
    end
    n_vec++; if (cyc_cnt - t0 != 8) begin n_err++; $display("FAIL b2b_write_cycles: got %0d expected 8", cyc_cnt - t0); end
    n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_write_data: got %h expected %h", reg_out, model_vec()); end
    ok = 1; t0 = cyc_cnt;
    for (int i = 0; i < 4; i++) begin
      a = 32'($urandom_range(0, NR-1)) << 2;
      do_read(a, rv, rd, rr, tmo);
      model_read(a, ed, err);
      if (tmo || rd !== ed || rr !== err) ok = 0;
    end
    n_vec++; if (cyc_cnt - t0 != 8) begin n_err++; $display("FAIL b2b_read_cycles: got %0d expected 8", cyc_cnt - t0); end
    n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_read_data: last got %h expected %h", rd, ed); end
  endtask

  task automatic test_random();
    logic bv, rv; logic [1:0] resp, eresp, rr, err; logic [NR-1:0] pulse, epulse; logic [32*NR-1:0] regs;
    logic [31:0] rd, ed, a, d; logic [3:0] s; bit early, tmo; int gap;
    for (int i = 0; i < 50; i++) begin
      a = (32'($urandom_range(0, NR+3)) << 2) | 32'($urandom_range(0, 3));
      d = $urandom; s = 4'($urandom); gap = $urandom_range(0, 6) - 3;
      do_write(a, d, s, gap, bv, resp, pulse, regs, early, tmo);
      model_write(a, d, s, eresp, epulse);
      n_vec++;
      if (tmo || early || bv !== 1'b1 || resp !== eresp || pulse !== epulse || regs !== model_vec()) begin
        n_err++;
        $display("FAIL rand_write[%0d] a=%h s=%h gap=%0d: got bv=%b resp=%b pulse=%h reg_out=%h expected 1/%b/%h/%h",
                 i, a, s, gap, bv, resp, pulse, regs, eresp, epulse, model_vec());
      end
      a = (32'($urandom_range(0, NR+3)) << 2) | 32'($urandom_range(0, 3));
      do_read(a, rv, rd, rr, tmo);
      model_read(a, ed, err);
      n_vec++;
      if (tmo || rv !== 1'b1 || rd !== ed || rr !== err) begin
        n_err++; $display("FAIL rand_read[%0d] a=%h: got %h/%b expected %h/%b", i, a, rd, rr, ed, err);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic rv; logic [31:0] rd; logic [1:0] rr; bit tmo, quiet;
    awaddr = 32'h4; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    n_vec++; if (awready !== 1'b0 || wready !== 1'b1) begin n_err++; $display("FAIL mid_have_aw: got awready=%b wready=%b expected 0,1", awready, wready); end
    areset = 1;
    @(posedge clk); #1;
    n_vec++; if (reg_out !== '0 || bvalid !== 1'b0 || awready !== 1'b0) begin n_err++; $display("FAIL mid_in_reset: got regs=%h bvalid=%b awready=%b expected 0", reg_out, bvalid, awready); end
    @(posedge clk); #1;
    areset = 0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(posedge clk); #1;
    n_vec++; if (awready !== 1'b1 || wready !== 1'b1) begin n_err++; $display("FAIL mid_readies: got %b%b expected 11", awready, wready); end
    quiet = 1;
    for (int i = 0; i < 6; i++) begin
      if (bvalid !== 1'b0 || reg_wr_pulse !== '0) quiet = 0;
      @(posedge clk); #1;
    end
    n_vec++; if (!quiet) begin n_err++; $display("FAIL mid_no_bvalid: got bvalid=%b expected 0", bvalid); end
    do_read(32'h4, rv, rd, rr, tmo);
    n_vec++; if (tmo || rd !== 32'h0) begin n_err++; $display("FAIL mid_reg1: got %h expected 0", rd); end
  endtask

  initial begin
    test_reset();
    test_simultaneous_write();
    test_backpressure();
    test_split_write();
    test_out_of_range();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
